// File: rtl/mem_arbiter_if.sv
// Signal bundle between the memory arbiter, its fetch/data requesters and the
// single-port memory. The slave modport is the arbiter's view.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = 3
) ();
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [LEN_W-1:0]  d_len;
  logic [DATA_W-1:0] d_wdata;
  logic [LEN_W-1:0]  d_beat;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_in;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] mem_out;
  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_len, d_wdata, mem_out,
    output if_ack, if_rdata, d_beat, d_ack, d_rdata, d_done,
    output mem_address, mem_in, mem_write, mem_read, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_len, d_wdata, mem_out,
    input  if_ack, if_rdata, d_beat, d_ack, d_rdata, d_done,
    input  mem_address, mem_in, mem_write, mem_read, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between a single-word fetch
// requester and a burst load/store data requester. All outputs are registered.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = 3
) (
  input  logic         clk,
  input  logic         proc_rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StAccess, StDrain} state_e;

  state_e            state_q, state_d;
  logic              gnt_data_q, gnt_data_d;
  logic              last_fetch_q, last_fetch_d;
  logic              we_q, we_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [LEN_W-1:0]  d_beat_q, d_beat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] mem_in_q, mem_in_d;
  logic              rd_n_q, rd_n_d;
  logic              wr_n_q, wr_n_d;
  logic              if_ack_q, if_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              d_ack_q, d_ack_d;
  logic              d_done_q, d_done_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d      = state_q;
    gnt_data_d   = gnt_data_q;
    last_fetch_d = last_fetch_q;
    we_d         = we_q;
    rem_d        = rem_q;
    d_beat_d     = d_beat_q;
    addr_d       = addr_q;
    mem_in_d     = mem_in_q;
    rd_n_d       = 1'b1;
    wr_n_d       = 1'b1;
    if_ack_d     = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_ack_d      = 1'b0;
    d_done_d     = 1'b0;
    d_rdata_d    = d_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (bus.if_req || bus.d_req) begin
          state_d = StAccess;
          // Data wins when it is the only requester or fetch was granted last.
          if (bus.d_req && (!bus.if_req || last_fetch_q)) begin
            gnt_data_d   = 1'b1;
            last_fetch_d = 1'b0;
            we_d         = bus.d_we;
            rem_d        = bus.d_len;
            addr_d       = bus.d_addr;
            d_beat_d     = d_beat_q + LEN_W'(1);
            if (bus.d_we) begin
              wr_n_d   = 1'b0;
              mem_in_d = bus.d_wdata;
            end else begin
              rd_n_d = 1'b0;
            end
          end else begin
            gnt_data_d   = 1'b0;
            last_fetch_d = 1'b1;
            rem_d        = '0;
            addr_d       = bus.if_addr;
            rd_n_d       = 1'b0;
          end
        end
      end
      StAccess: begin
        if (gnt_data_q) begin
          // Ack the beat whose strobe was low this cycle; issue the next if any.
          d_ack_d = 1'b1;
          if (!we_q) d_rdata_d = bus.mem_out;
          if (rem_q == '0) begin
            d_done_d = 1'b1;
            d_beat_d = '0;
            state_d  = StDrain;
          end else begin
            rem_d    = rem_q - LEN_W'(1);
            addr_d   = addr_q + ADDR_W'(1);
            d_beat_d = d_beat_q + LEN_W'(1);
            if (we_q) begin
              wr_n_d   = 1'b0;
              mem_in_d = bus.d_wdata;
            end else begin
              rd_n_d = 1'b0;
            end
          end
        end else begin
          if_ack_d   = 1'b1;
          if_rdata_d = bus.mem_out;
          state_d    = StDrain;
        end
      end
      StDrain: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!proc_rst) begin
      state_q      <= StIdle;
      gnt_data_q   <= 1'b0;
      last_fetch_q <= 1'b0;
      we_q         <= 1'b0;
      rem_q        <= '0;
      d_beat_q     <= '0;
      addr_q       <= '0;
      mem_in_q     <= '0;
      rd_n_q       <= 1'b1;
      wr_n_q       <= 1'b1;
      if_ack_q     <= 1'b0;
      if_rdata_q   <= '0;
      d_ack_q      <= 1'b0;
      d_done_q     <= 1'b0;
      d_rdata_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_data_q   <= gnt_data_d;
      last_fetch_q <= last_fetch_d;
      we_q         <= we_d;
      rem_q        <= rem_d;
      d_beat_q     <= d_beat_d;
      addr_q       <= addr_d;
      mem_in_q     <= mem_in_d;
      rd_n_q       <= rd_n_d;
      wr_n_q       <= wr_n_d;
      if_ack_q     <= if_ack_d;
      if_rdata_q   <= if_rdata_d;
      d_ack_q      <= d_ack_d;
      d_done_q     <= d_done_d;
      d_rdata_q    <= d_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.if_ack      = if_ack_q;
  assign bus.if_rdata    = if_rdata_q;
  assign bus.d_beat      = d_beat_q;
  assign bus.d_ack       = d_ack_q;
  assign bus.d_done      = d_done_q;
  assign bus.d_rdata     = d_rdata_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_in      = mem_in_q;
  assign bus.mem_read    = rd_n_q;
  assign bus.mem_write   = wr_n_q;
  assign bus.busy        = busy_q;
endmodule
